// File: rtl/booth_wallace_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_wallace_pipe_pkg
// Brief    : Shared widths, row types and the 3:2 compressor for the Booth tree.
// Revision : 1.0
// ============================================================================
package booth_wallace_pipe_pkg;

    localparam int PPW    = 34;
    localparam int NPP    = 17;
    localparam int SW     = 68;
    localparam int TAG_W  = 5;
    localparam int PROD_W = 64;

    typedef logic [SW-1:0]             row_t;
    typedef logic [NPP-1:0][PPW-1:0]   pp_bus_t;

    typedef struct packed {
        row_t sum;
        row_t carry;
    } csa_out_t;

    // Carry leaves the top bit behind: the tree works modulo 2^SW.
    function automatic csa_out_t csa32_f(input row_t a, input row_t b, input row_t c);
        csa_out_t r;
        r.sum   = a ^ b ^ c;
        r.carry = ((a & b) | (a & c) | (b & c)) << 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_wallace_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_wallace_pipe_if
// Brief    : Operand/result handshake bundle between Booth generator and tree.
// Revision : 1.0
// ============================================================================
interface booth_wallace_pipe_if;
    import booth_wallace_pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [TAG_W-1:0]  in_tag;
    pp_bus_t           pp;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [PROD_W-1:0] prod;

    modport master (
        output in_valid, in_tag, pp, flush, out_ready,
        input  in_ready, out_valid, out_tag, prod
    );

    modport slave (
        input  in_valid, in_tag, pp, flush, out_ready,
        output in_ready, out_valid, out_tag, prod
    );

endinterface
`default_nettype wire

// File: rtl/booth_wallace_pipe_csa32.sv
`default_nettype none
// ============================================================================
// Module   : booth_wallace_pipe_csa32
// Brief    : Row-wide 3:2 carry-save compressor, purely combinational.
// Revision : 1.0
// ============================================================================
module booth_wallace_pipe_csa32
    import booth_wallace_pipe_pkg::*;
(
    input  row_t i_a,
    input  row_t i_b,
    input  row_t i_c,
    output row_t o_sum,
    output row_t o_carry
);

    csa_out_t w_res;

    assign w_res   = csa32_f(i_a, i_b, i_c);
    assign o_sum   = w_res.sum;
    assign o_carry = w_res.carry;

endmodule
`default_nettype wire

// File: rtl/booth_wallace_pipe.sv
`default_nettype none
// ============================================================================
// Module   : booth_wallace_pipe
// Brief    : 3-stage Wallace reduction + final add of 17 Booth partial products.
// Revision : 1.0
// ============================================================================
module booth_wallace_pipe
    import booth_wallace_pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    booth_wallace_pipe_if.slave  bus
);

    row_t w_l0 [NPP];
    row_t w_l1 [12];
    row_t w_l2 [8];
    row_t w_l3 [6];
    row_t w_m1 [4];
    row_t w_m2 [3];
    row_t w_s2_sum;
    row_t w_s2_carry;
    row_t w_s3;
    logic [PROD_W-1:0] w_prod_next;
    logic w_unused;

    row_t r_s1_rows [6];
    row_t r_s2_sum;
    row_t r_s2_carry;
    logic [TAG_W-1:0]  r_s1_tag;
    logic [TAG_W-1:0]  r_s2_tag;
    logic [TAG_W-1:0]  r_out_tag;
    logic [PROD_W-1:0] r_prod;
    logic r_v1, r_v2, r_v3;
    logic w_adv1, w_adv2, w_adv3;

    // Stage 1: align each partial product to weight 4^i, then 17 -> 12 -> 8 -> 6.
    for (genvar i = 0; i < NPP; i++) begin : g_ext
        assign w_l0[i] = {{(SW-PPW){bus.pp[i][PPW-1]}}, bus.pp[i]} << (2*i);
    end

    for (genvar g = 0; g < 5; g++) begin : g_l1
        booth_wallace_pipe_csa32 u_csa (
            .i_a(w_l0[3*g]), .i_b(w_l0[3*g+1]), .i_c(w_l0[3*g+2]),
            .o_sum(w_l1[2*g]), .o_carry(w_l1[2*g+1])
        );
    end
    assign w_l1[10] = w_l0[15];
    assign w_l1[11] = w_l0[16];

    for (genvar g = 0; g < 4; g++) begin : g_l2
        booth_wallace_pipe_csa32 u_csa (
            .i_a(w_l1[3*g]), .i_b(w_l1[3*g+1]), .i_c(w_l1[3*g+2]),
            .o_sum(w_l2[2*g]), .o_carry(w_l2[2*g+1])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_l3
        booth_wallace_pipe_csa32 u_csa (
            .i_a(w_l2[3*g]), .i_b(w_l2[3*g+1]), .i_c(w_l2[3*g+2]),
            .o_sum(w_l3[2*g]), .o_carry(w_l3[2*g+1])
        );
    end
    assign w_l3[4] = w_l2[6];
    assign w_l3[5] = w_l2[7];

    // Stage 2: 6 -> 4 -> 3 -> 2.
    for (genvar g = 0; g < 2; g++) begin : g_m1
        booth_wallace_pipe_csa32 u_csa (
            .i_a(r_s1_rows[3*g]), .i_b(r_s1_rows[3*g+1]), .i_c(r_s1_rows[3*g+2]),
            .o_sum(w_m1[2*g]), .o_carry(w_m1[2*g+1])
        );
    end

    booth_wallace_pipe_csa32 u_m2 (
        .i_a(w_m1[0]), .i_b(w_m1[1]), .i_c(w_m1[2]),
        .o_sum(w_m2[0]), .o_carry(w_m2[1])
    );
    assign w_m2[2] = w_m1[3];

    booth_wallace_pipe_csa32 u_m3 (
        .i_a(w_m2[0]), .i_b(w_m2[1]), .i_c(w_m2[2]),
        .o_sum(w_s2_sum), .o_carry(w_s2_carry)
    );

    // Stage 3: the Booth rows encode 2*y, so the product sits one bit up.
    assign w_s3        = r_s2_sum + r_s2_carry;
    assign w_prod_next = w_s3[PROD_W:1];
    assign w_unused    = ^{w_s3[SW-1:PROD_W+1], w_s3[0]};

    assign w_adv3 = !r_v3 || bus.out_ready;
    assign w_adv2 = !r_v2 || w_adv3;
    assign w_adv1 = !r_v1 || w_adv2;

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_v3;
    assign bus.out_tag   = r_out_tag;
    assign bus.prod      = r_prod;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_s1_tag  <= '0;
            r_s2_tag  <= '0;
            r_out_tag <= '0;
            r_prod    <= '0;
        end else if (bus.flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1     <= bus.in_valid;
                r_s1_tag <= bus.in_tag;
            end
            if (w_adv2) begin
                r_v2     <= r_v1;
                r_s2_tag <= r_s1_tag;
            end
            // Result regs only move on a real result so they stay put across bubbles.
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_out_tag <= r_s2_tag;
                    r_prod    <= w_prod_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv1 && bus.in_valid) begin
            r_s1_rows <= w_l3;
        end
        if (w_adv2 && r_v1) begin
            r_s2_sum   <= w_s2_sum;
            r_s2_carry <= w_s2_carry;
        end
    end

endmodule
`default_nettype wire
